fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the PC register. It consumes the current PC and produces the next-PC value that the PC register loads every clock. It issues one instruction-memory request at a time over a valid/ready handshake and buffers returned {pc, instr} pairs in a 2-entry queue. The queue feeds decode over valid/ready, and the block handles branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, value the PC register resets to; used for the fetch address while in IDLE.
- BUF_DEPTH, 2, entries in the fetch queue; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  current PC, from the PC register output.
- npc  out  32  next PC, to the PC register input; the PC register loads it every clock.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_resp_valid  in  1  response valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken (single-cycle pulse).
- redirect_target  in  32  redirect address.
- id_valid  out  1  queue head valid toward decode.
- id_ready  in  1  decode accepts the head.
- id_instr  out  32  head instruction; 32'h0 when the queue is empty.
- id_pc  out  32  head PC; 32'h0 when the queue is empty.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset: state=IDLE, queue empty, req_pc reg=0.
  - Outputs during reset: imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, npc=pc.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE -> REQ unconditionally on the first clock after reset deasserts.
  - REQ: imem_req_valid = (count + 0 < BUF_DEPTH) and !redirect_valid. On handshake (valid & ready), capture req_pc=pc and go to WAIT.
  - WAIT: on imem_resp_valid, push {req_pc, imem_resp_data} and go to REQ.
  - DROP: on imem_resp_valid, discard the data and go to REQ.
  - Credit rule: a request is issued only when count + outstanding < BUF_DEPTH. Therefore a push never overflows.
- npc priority:
  1. redirect_valid -> {redirect_target[31:2], 2'b00}
  2. request handshake this cycle -> pc + 4 (32-bit, wraps from 32'hFFFF_FFFC to 0)
  3. otherwise -> pc (hold)
- Redirect (any state): queue flushed at the clock edge; id_valid=0 on the next cycle.
  - WAIT -> DROP.
  - REQ -> REQ. No handshake is possible because req_valid is masked.
  - DROP stays DROP.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is still honoured for decode; decode is responsible for squashing it.
- Queue: 2-entry FIFO, head drives the id_* outputs.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full with an in-flight push.
  - Flush has priority over push.
- Throughput: at most 1 instruction per 2 cycles (REQ then WAIT, minimum).
- Memory stall: while imem_req_ready=0 in REQ, imem_req_addr and npc hold pc and no state changes.
- Reset mid-operation: everything returns to reset values asynchronously.
  - A response for a request that was outstanding at reset must not be pushed. IDLE and REQ ignore imem_resp_valid.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {IDLE, REQ, WAIT, DROP}
  - localparams PC_STEP=32'd4, INSTR_NOP=32'h0
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Asynchronous active-high reset.

Test Plan:
- Reset: assert rst mid-WAIT, then release -> id_valid=0, imem_req_valid=0 for 1 cycle (IDLE), then a request at addr 0x0; npc=0x4 on the handshake cycle.
- Streaming: 1-cycle memory returning 0x1111_0000+addr, id_ready=1 -> decode sees (pc 0x0, 0x1111_0000), (0x4, 0x1111_0004), (0x8, 0x1111_0008), one every 2 cycles.
- Backpressure: id_ready=0 -> exactly 2 entries (0x0, 0x4) buffered; imem_req_valid stays 0 and npc=pc=0x8 held. Raise id_ready -> 0x0, 0x4, 0x8 delivered in order.
- Memory stall: imem_req_ready=0 for 3 cycles at pc 0x8 -> imem_req_addr=0x8 and npc=0x8 each cycle; handshake on the 4th cycle -> npc=0xC.
- Redirect in WAIT: outstanding fetch at 0x4, redirect_target=0x102 -> npc=0x100 and the 0x4 response is discarded; the next id_pc is 0x100 with no stale entry.
- Redirect with a simultaneous response and a full queue: queue empty next cycle, the response is dropped, then fetch resumes at the target.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} pairs between fetch and decode.
// Flush wins over push; push and pop may coincide at any occupancy.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state of storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // When full, a push only lands if the head leaves in the same cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is zeroed when empty so decode never sees stale contents.
    always_comb begin
        count = count_q;
        if (count_q != 2'd0) begin
            head = mem_q[rd_ptr_q];
        end else begin
            head = '{pc: 32'h0, instr: INSTR_NOP};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: computes next PC, issues one memory request at a
// time, queues returned {pc, instr} pairs and handles redirects.
// Handshakes: a transfer happens on a cycle where valid && ready; valid
// never depends on ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         req_valid;
    logic         handshake;
    logic         push;
    logic         pop;
    logic [1:0]   buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t push_data;

    // Fetch FSM: request issue, response capture and redirect dropping.
    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        req_valid = 1'b0;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // Only one request is ever outstanding, so credit is the queue count.
                req_valid = (buf_count < DEPTH_C) && !redirect_valid;
                if (req_valid && imem_req_ready) begin
                    req_pc_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // A response in the redirect cycle retires the request; otherwise drop it later.
                    state_d = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured request PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next-PC selection: redirect, then sequential step on accept, else hold.
    always_comb begin
        handshake = req_valid && imem_req_ready;
        if (redirect_valid && !rst) begin
            npc = align_word(redirect_target);
        end else if (handshake) begin
            npc = pc + PC_STEP;
        end else begin
            npc = pc;
        end
    end

    // Queue side-band and decode-facing outputs.
    always_comb begin
        push_data      = '{pc: req_pc_q, instr: imem_resp_data};
        imem_req_valid = req_valid;
        imem_req_addr  = pc;
        id_valid       = (buf_count != 2'd0);
        id_instr       = buf_head.instr;
        id_pc          = buf_head.pc;
        pop            = id_valid && id_ready;
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head      (buf_head)
    );

endmodule
